// File: rtl/weight_fetch.sv
// Streams KSIZE-word weight kernels from memory over a burst read channel into
// the kernel weight FIFO, one burst per kernel, pulsing weight_load after each.
module weight_fetch #(
  parameter int DW    = 32,
  parameter int KSIZE = 9,
  parameter int AW    = 32,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] num_ker,
  output logic [AW-1:0] araddr,
  output logic [7:0]    arlen,
  output logic          arvalid,
  input  logic          arready,
  input  logic [DW-1:0] rdata,
  input  logic          rvalid,
  input  logic          rlast,
  output logic          rready,
  output logic [DW-1:0] w_data,
  output logic          w_valid,
  input  logic          w_full,
  output logic          weight_load,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    LOAD = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int            BCW     = $clog2(KSIZE + 1);
  localparam logic [AW-1:0] STRIDE  = AW'(KSIZE * (DW / 8));
  localparam logic [BCW-1:0] BC_LAST = BCW'(KSIZE - 1);

  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [CW-1:0]  ki_q, ki_d;
  logic [CW-1:0]  num_q, num_d;
  logic [BCW-1:0] bc_q, bc_d;
  logic           err_q, err_d;
  logic           r_hs;

  // Handshake and FIFO strobe are combinational so a full FIFO stalls the beat in place.
  assign rready      = (state_q == DATA) && !w_full;
  assign r_hs        = rvalid && rready;
  assign w_valid     = r_hs;
  assign w_data      = rdata;
  assign arvalid     = (state_q == ADDR);
  assign araddr      = addr_q;
  assign arlen       = 8'(KSIZE - 1);
  assign weight_load = (state_q == LOAD);
  assign done        = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign err         = err_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ki_d    = ki_q;
    num_d   = num_q;
    bc_d    = bc_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = base_addr;
          num_d  = num_ker;
          ki_d   = '0;
          bc_d   = '0;
          err_d  = 1'b0;
          if (num_ker != '0) begin
            state_d = ADDR;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (arready) begin
          state_d = DATA;
          bc_d    = '0;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (r_hs) begin
          // Framing errors are only flagged; the beat count alone ends the burst.
          if ((bc_q == BC_LAST) != rlast) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (bc_q == BC_LAST) begin
            state_d = LOAD;
            bc_d    = '0;
          end else begin
            bc_d = bc_q + BCW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      LOAD: begin
        ki_d   = ki_q + CW'(1);
        addr_d = addr_q + STRIDE;
        if (ki_q == num_q - CW'(1)) begin
          state_d = DONE;
        end else begin
          state_d = ADDR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ki_q    <= '0;
      num_q   <= '0;
      bc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ki_q    <= ki_d;
      num_q   <= num_d;
      bc_q    <= bc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/weight_fetch.md
WEIGHT_FETCH -- requirements
Module: weight_fetch

Interface
REQ-001 SHALL have parameter DW, default 32, weight word width in bits.
REQ-002 SHALL have parameter KSIZE, default 9, weights per kernel (k**2).
REQ-003 SHALL have parameter AW, default 32, memory address width.
REQ-004 SHALL have parameter CW, default 16, kernel-count width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 Ports, in order:
 - clk  in  1  rising-edge clock.
 - rst  in  1  asynchronous reset, active-high.
 - start  in  1  one-cycle pulse that begins a fetch job.
 - base_addr  in  AW  byte address of kernel 0, sampled on accepted start.
 - num_ker  in  CW  number of kernels to fetch, sampled on accepted start.
 - araddr  out  AW  read burst address.
 - arlen  out  8  burst length minus 1; constant KSIZE-1.
 - arvalid  out  1  address request valid.
 - arready  in  1  address request accepted.
 - rdata  in  DW  read data beat.
 - rvalid  in  1  read beat valid.
 - rlast  in  1  last beat of the burst.
 - rready  out  1  read beat accepted.
 - w_data  out  DW  weight word to the kernel weight FIFO.
 - w_valid  out  1  one-cycle write strobe to the FIFO.
 - w_full  in  1  FIFO full; no write strobe while high.
 - weight_load  out  1  one-cycle pulse after a complete kernel is written.
 - busy  out  1  high from accepted start until done.
 - done  out  1  one-cycle pulse at job end.
 - err  out  1  sticky burst-framing error.

Function
REQ-007 FSM states: IDLE, ADDR, DATA, LOAD, DONE.
REQ-008 IDLE: start=1 with num_ker!=0 -> ADDR; base_addr/num_ker latched, kernel index ki=0, err cleared.
REQ-009 IDLE: start=1 with num_ker==0 -> DONE; no arvalid issued.
REQ-010 start SHALL be ignored outside IDLE.
REQ-011 ADDR: arvalid=1, araddr=base+ki*KSIZE*(DW/8), truncated mod 2**AW; arvalid and araddr held stable until arready; on arvalid&arready -> DATA, beat counter bc=0.
REQ-012 DATA: rready = ~w_full; all other states rready=0.
REQ-013 w_valid SHALL be combinational rvalid&rready; w_data = rdata; one FIFO write per handshake, none otherwise.
REQ-014 Each handshake increments bc; the handshake at bc==KSIZE-1 -> LOAD.
REQ-015 Framing: rlast=1 on a handshake with bc!=KSIZE-1, or rlast=0 with bc==KSIZE-1, SHALL set err; the beat count still governs the transition.
REQ-016 LOAD: weight_load=1 for exactly one cycle; ki increments; ki==num_ker-1 before increment -> DONE, else -> ADDR.
REQ-017 DONE: done=1 for one cycle -> IDLE.
REQ-018 busy=1 in ADDR, DATA, LOAD, DONE; 0 in IDLE.
REQ-019 Only one burst SHALL be outstanding; the next arvalid rises no earlier than the cycle after LOAD.
REQ-020 Zero-stall latency: a kernel takes 1 (ADDR, arready=1) + KSIZE (DATA) + 1 (LOAD) cycles; weight_load is 1 cycle after the last w_valid.
REQ-021 w_full high while rvalid=1: no handshake, bc held, no beat lost; resume when w_full falls.
REQ-022 err SHALL hold until the next accepted start or reset.

Reset
REQ-023 On rst (any time, including mid-burst): state=IDLE, ki=0, bc=0, err=0; arvalid, rready, w_valid, weight_load, busy, done all 0.
REQ-024 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-025 start, base=0x1000, num_ker=2, arready/rvalid always 1, w_full=0 -> araddr 0x1000 then 0x1024, 18 w_valid strobes, weight_load on cycles 11 and 22 after start, done on cycle 23.
REQ-026 num_ker=0 -> done one cycle after start; arvalid never 1; busy high one cycle.
REQ-027 w_full=1 for 3 cycles at beat 4 -> rready=0 for those cycles; still exactly 9 w_valid in order; weight_load delayed 3 cycles.
REQ-028 rlast on beat 5 of 9 -> err=1 sticky, 9 writes and weight_load still occur; next start clears err.
REQ-029 rst asserted during DATA at beat 6 -> all outputs 0 in the same cycle; new start fetches kernel 0 from the new base_addr.
REQ-030 base_addr=0xFFFFFFF0, num_ker=2 -> second araddr=0x00000014 (wrap mod 2**32).
